// File: rtl/csr_trap_unit_pkg.sv
// Shared types and constants for the machine-mode CSR / trap unit.
package csr_trap_unit_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RSV  = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_t;

  typedef enum logic {
    IDLE,
    REDIRECT
  } trap_fsm_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] MCAUSE_M_TIMER = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIP_MTIP     = 7;

  function automatic logic csr_op_writes(csr_op_t op);
    return !(op inside {CSR_OP_NONE, CSR_OP_RSV});
  endfunction

  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old, logic [31:0] wdata);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: return wdata;
      CSR_OP_RS, CSR_OP_RSI: return old | wdata;
      CSR_OP_RC, CSR_OP_RCI: return old & ~wdata;
      default:               return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Pipeline <-> CSR/trap unit signal bundle; master is the pipeline side.
interface csr_trap_unit_if;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic        mret_valid;
  logic        ecall_valid;
  logic [31:0] current_pc;
  logic        instr_retire;
  logic        timer_irq;
  logic        irq_ok;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output csr_valid, csr_addr, csr_op, csr_wdata, csr_write,
    output mret_valid, ecall_valid, current_pc, instr_retire, timer_irq, irq_ok,
    input  csr_rdata, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_valid, csr_addr, csr_op, csr_wdata, csr_write,
    input  mret_valid, ecall_valid, current_pc, instr_retire, timer_irq, irq_ok,
    output csr_rdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running counter with independent software writes to each 32-bit half.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] sum;

  assign sum = value + 64'(inc);

  // A written half takes wdata; the other half still sees the carry of the full-width sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      value[31:0]  <= wr_lo ? wdata : sum[31:0];
      value[63:32] <= wr_hi ? wdata : sum[63:32];
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus ecall/timer-irq/mret sequencing into a one-cycle PC redirect.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [31:0] MHARTID     = 32'h0
) (
  input logic            clk,
  input logic            reset_n,
  csr_trap_unit_if.slave csr_bus
);

  trap_fsm_t   state;
  logic        mstatus_mie, mstatus_mpie, mtip_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_v, minstret_v;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  csr_op_t     op;
  logic [11:0] addr;
  logic [31:0] mstatus_rd, rd_val, wr_val;
  logic        in_idle, irq, take_ecall, take_irq, take_mret, take_trap, take_any;
  logic        wr_en, wr_sys;

  assign op   = csr_op_t'(csr_bus.csr_op);
  assign addr = csr_bus.csr_addr;

  always_comb begin
    mstatus_rd               = 32'h0000_1800;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MIP:       rd_val[MIP_MTIP] = mtip_q;
      CSR_MCYCLE:    rd_val = mcycle_v[31:0];
      CSR_MCYCLEH:   rd_val = mcycle_v[63:32];
      CSR_MINSTRET:  rd_val = minstret_v[31:0];
      CSR_MINSTRETH: rd_val = minstret_v[63:32];
      CSR_MHARTID:   rd_val = MHARTID;
      default:       rd_val = '0;
    endcase
  end

  assign csr_bus.csr_rdata = csr_bus.csr_valid ? rd_val : '0;

  assign in_idle    = (state == IDLE);
  assign irq        = mstatus_mie & mie_q[MIE_MTIE] & mtip_q & csr_bus.irq_ok;
  assign take_ecall = in_idle & csr_bus.ecall_valid;
  assign take_irq   = in_idle & ~csr_bus.ecall_valid & irq;
  assign take_mret  = in_idle & ~csr_bus.ecall_valid & ~irq & csr_bus.mret_valid;
  assign take_trap  = take_ecall | take_irq;
  assign take_any   = take_trap | take_mret;

  assign wr_en  = in_idle & csr_bus.csr_valid & csr_bus.csr_write & csr_op_writes(op);
  assign wr_val = csr_apply(op, rd_val, csr_bus.csr_wdata);
  // Trap/mret sequencing owns mstatus/mepc/mcause in its cycle; other CSRs still take the write.
  assign wr_sys = wr_en & ~take_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtip_q       <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= RESET_MTVEC & 32'hFFFF_FFFC;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      mtip_q <= csr_bus.timer_irq;
      if (wr_en) begin
        case (addr)
          CSR_MIE:      mie_q      <= wr_val;
          CSR_MTVEC:    mtvec_q    <= wr_val & 32'hFFFF_FFFC;
          CSR_MSCRATCH: mscratch_q <= wr_val;
          default: ;
        endcase
      end
      if (wr_sys) begin
        case (addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= wr_val[MSTATUS_MIE];
            mstatus_mpie <= wr_val[MSTATUS_MPIE];
          end
          CSR_MEPC:   mepc_q   <= wr_val & 32'hFFFF_FFFC;
          CSR_MCAUSE: mcause_q <= wr_val;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q       <= csr_bus.current_pc & 32'hFFFF_FFFC;
        mcause_q     <= take_ecall ? MCAUSE_ECALL_M : MCAUSE_M_TIMER;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_any) begin
            state            <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= take_trap ? mtvec_q : mepc_q;
          end
        end
        REDIRECT: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_bus.redirect_valid = redirect_valid_q;
  assign csr_bus.redirect_pc    = redirect_pc_q;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wr_lo   (wr_en && addr == CSR_MCYCLE),
    .wr_hi   (wr_en && addr == CSR_MCYCLEH),
    .wdata   (wr_val),
    .value   (mcycle_v)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (csr_bus.instr_retire),
    .wr_lo   (wr_en && addr == CSR_MINSTRET),
    .wr_hi   (wr_en && addr == CSR_MINSTRETH),
    .wdata   (wr_val),
    .value   (minstret_v)
  );

endmodule
